// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - in-place radix-2 DIT FFT address sequencer
// Issues butterfly read/twiddle addresses per stage and the delayed write-back addresses.
module fft_stage_ctrl #(
  parameter int LOG2N  = 4,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1,
  localparam int D     = RD_LAT + BF_LAT,
  localparam int SW    = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam int DW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] a_q, b_q;
  logic [LOG2N-2:0] tw_q;

  logic             wr_en_pipe [D];
  logic [LOG2N-1:0] wa_pipe    [D];
  logic [LOG2N-1:0] wb_pipe    [D];

  // Operand A is k with a zero bit inserted at position s; B sets that bit.
  function automatic logic [LOG2N-1:0] addr_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOG2N-1:0] kk;
    logic [LOG2N-1:0] m;
    kk = {1'b0, k};
    m  = (LOG2N'(1) << s) - LOG2N'(1);
    return (((kk >> s) << 1) << s) | (kk & m);
  endfunction

  function automatic logic [LOG2N-1:0] addr_b(input logic [SW-1:0] s, input logic [KW-1:0] k);
    return addr_a(s, k) | (LOG2N'(1) << s);
  endfunction

  function automatic logic [LOG2N-2:0] tw_idx(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOG2N-1:0] kk;
    logic [LOG2N-1:0] t;
    int               sh;
    kk = {1'b0, k};
    sh = LOG2N - 1 - int'(s);
    t  = (kk & ((LOG2N'(1) << s) - LOG2N'(1))) << sh;
    return t[LOG2N-2:0];
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    rd_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
          rd_en_d = 1'b1;
        end
      end
      RUN: begin
        if (k_q == '1) begin
          state_d = DRAIN;
          dcnt_d  = DW'(D);
        end else begin
          k_d     = k_q + KW'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(1)) begin
          if (s_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
            k_d     = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      rd_en_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      rd_en_q <= rd_en_d;
      // addresses only move on a read issue, so they hold through drain
      if (rd_en_d) begin
        a_q  <= addr_a(s_d, k_d);
        b_q  <= addr_b(s_d, k_d);
        tw_q <= tw_idx(s_d, k_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        wr_en_pipe[i] <= 1'b0;
        wa_pipe[i]    <= '0;
        wb_pipe[i]    <= '0;
      end
    end else begin
      wr_en_pipe[0] <= rd_en_q;
      wa_pipe[0]    <= a_q;
      wb_pipe[0]    <= b_q;
      for (int i = 1; i < D; i++) begin
        wr_en_pipe[i] <= wr_en_pipe[i-1];
        wa_pipe[i]    <= wa_pipe[i-1];
        wb_pipe[i]    <= wb_pipe[i-1];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign stage     = s_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = a_q;
  assign rd_addr_b = b_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wr_en_pipe[D-1];
  assign wr_addr_a = wa_pipe[D-1];
  assign wr_addr_b = wb_pipe[D-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - scoreboard bench for fft_stage_ctrl
// Main instance LOG2N=4, D=2; small instance LOG2N=2, RD_LAT=0, BF_LAT=1.
module tb_fft_stage_ctrl;

  localparam int LN     = 4;
  localparam int H      = 8;
  localparam int DD     = 2;
  localparam int P      = H + DD;
  localparam int DONE_C = LN * P + 1;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;

  logic       rst2, start2;
  logic       busy2, done2, rd_en2, wr_en2;
  logic [0:0] stage2;
  logic [1:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
  logic [0:0] tw_addr2;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2N(4), .RD_LAT(1), .BF_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  fft_stage_ctrl #(.LOG2N(2), .RD_LAT(0), .BF_LAT(1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2), .stage(stage2),
    .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
    .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2)
  );

  typedef struct {
    logic       busy, done, rd_en, wr_en;
    logic [3:0] a, b, wa, wb;
    logic [2:0] tw;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // expected small-instance trace, cycles 1..8
  int t_rd  [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
  int t_a   [8] = '{0, 2, 0, 0, 1, 0, 0, 0};
  int t_b   [8] = '{1, 3, 0, 2, 3, 0, 0, 0};
  int t_tw  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int t_wr  [8] = '{0, 1, 1, 0, 1, 1, 0, 0};
  int t_wa  [8] = '{0, 0, 2, 0, 0, 1, 0, 0};
  int t_wb  [8] = '{0, 1, 3, 0, 2, 3, 0, 0};
  int t_dn  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int t_bs  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void rd_model(input int c, output logic en, output logic [3:0] a,
                                   output logic [3:0] b, output logic [2:0] tw, output logic [1:0] st);
    int s, o, h, j;
    en = 1'b0; a = '0; b = '0; tw = '0; st = '0;
    if (c >= 1 && c <= LN * P) begin
      s  = (c - 1) / P;
      o  = (c - 1) % P;
      st = 2'(s);
      if (o < H) begin
        h  = 1 << s;
        j  = o % h;
        en = 1'b1;
        a  = 4'(((o >> s) << (s + 1)) | j);
        b  = 4'(int'(a) + h);
        tw = 3'(j << (LN - 1 - s));
      end
    end
  endfunction

  task automatic build(input int ncyc, input bit hold);
    exp_t       e;
    logic [2:0] dtw;
    logic [1:0] dst;
    int         cc;
    for (int c = 1; c <= ncyc; c++) begin
      cc = (hold && c > DONE_C + 1) ? c - (DONE_C + 1) : c;
      e.busy = (cc >= 1 && cc <= DONE_C);
      e.done = (cc == DONE_C);
      rd_model(cc, e.rd_en, e.a, e.b, e.tw, e.st);
      rd_model(cc - DD, e.wr_en, e.wa, e.wb, dtw, dst);
      sb.push_back(e);
    end
  endtask

  task automatic run_check(input int ncyc, input bit hold);
    exp_t e;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      e = sb.pop_front();
      chk($sformatf("c%0d busy", c), 32'(busy), 32'(e.busy));
      chk($sformatf("c%0d done", c), 32'(done), 32'(e.done));
      chk($sformatf("c%0d rd_en", c), 32'(rd_en), 32'(e.rd_en));
      if (e.rd_en) begin
        chk($sformatf("c%0d rd_addr_a", c), 32'(rd_addr_a), 32'(e.a));
        chk($sformatf("c%0d rd_addr_b", c), 32'(rd_addr_b), 32'(e.b));
        chk($sformatf("c%0d tw_addr", c), 32'(tw_addr), 32'(e.tw));
        chk($sformatf("c%0d stage", c), 32'(stage), 32'(e.st));
      end
      chk($sformatf("c%0d wr_en", c), 32'(wr_en), 32'(e.wr_en));
      if (e.wr_en) begin
        chk($sformatf("c%0d wr_addr_a", c), 32'(wr_addr_a), 32'(e.wa));
        chk($sformatf("c%0d wr_addr_b", c), 32'(wr_addr_b), 32'(e.wb));
      end
      if (c == 26) begin
        chk("s2k5 a", 32'(rd_addr_a), 32'd9);
        chk("s2k5 b", 32'(rd_addr_b), 32'd13);
        chk("s2k5 tw", 32'(tw_addr), 32'd2);
      end
      if (c == 34) begin
        chk("s3k3 a", 32'(rd_addr_a), 32'd3);
        chk("s3k3 b", 32'(rd_addr_b), 32'd11);
        chk("s3k3 tw", 32'(tw_addr), 32'd3);
      end
    end
  endtask

  task automatic begin_run(input int ncyc, input bit hold);
    @(negedge clk);
    start = 1'b1;
    build(ncyc, hold);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rd_en", 32'(rd_en), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst stage", 32'(stage), 32'd0);
    chk("rst rd_addr_a", 32'(rd_addr_a), 32'd0);
    chk("rst wr_addr_b", 32'(wr_addr_b), 32'd0);
    chk("rst tw_addr", 32'(tw_addr), 32'd0);
    chk("rst2 busy", 32'(busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // single start pulse, full transform plus one idle cycle
    begin_run(DONE_C + 1, 1'b0);
    run_check(DONE_C + 1, 1'b0);

    // start held high: no restart mid-run, new transform right after done
    begin_run(DONE_C + 2, 1'b1);
    run_check(DONE_C + 2, 1'b1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset in cycle 20
    begin_run(19, 1'b0);
    run_check(19, 1'b0);
    @(negedge clk);
    chk("c20 pre busy", 32'(busy), 32'd1);
    chk("c20 pre wr_en", 32'(wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst rd_en", 32'(rd_en), 32'd0);
    chk("arst wr_en", 32'(wr_en), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst%0d wr_en", i), 32'(wr_en), 32'd0);
      chk($sformatf("post-rst%0d busy", i), 32'(busy), 32'd0);
    end

    // restart after reset begins from stage 0, k 0
    begin_run(DONE_C + 1, 1'b0);
    run_check(DONE_C + 1, 1'b0);

    // small configuration
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      chk($sformatf("n4 c%0d busy", c), 32'(busy2), 32'(t_bs[c-1]));
      chk($sformatf("n4 c%0d done", c), 32'(done2), 32'(t_dn[c-1]));
      chk($sformatf("n4 c%0d rd_en", c), 32'(rd_en2), 32'(t_rd[c-1]));
      if (t_rd[c-1] != 0) begin
        chk($sformatf("n4 c%0d rd_addr_a", c), 32'(rd_addr_a2), 32'(t_a[c-1]));
        chk($sformatf("n4 c%0d rd_addr_b", c), 32'(rd_addr_b2), 32'(t_b[c-1]));
        chk($sformatf("n4 c%0d tw_addr", c), 32'(tw_addr2), 32'(t_tw[c-1]));
      end
      chk($sformatf("n4 c%0d wr_en", c), 32'(wr_en2), 32'(t_wr[c-1]));
      if (t_wr[c-1] != 0) begin
        chk($sformatf("n4 c%0d wr_addr_a", c), 32'(wr_addr_a2), 32'(t_wa[c-1]));
        chk($sformatf("n4 c%0d wr_addr_b", c), 32'(wr_addr_b2), 32'(t_wb[c-1]));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequences an in-place radix-2 DIT FFT of N points over a dual-port sample memory, twiddle ROM and one butterfly unit.
- Per cycle, issues read addresses for operands A and B plus the twiddle index for one butterfly.
- Issues the matching write-back addresses after the memory-plus-butterfly pipeline delay.
- Runs all log2(N) stages, inserts drain gaps between stages so in-place read-after-write ordering holds, and reports busy/done to the top-level controller.

Parameters:
- LOG2N, 4, log2 of FFT size; N = 2**LOG2N, legal range 2..12.
- RD_LAT, 1, cycles from rd_en/rd_addr to data at butterfly inputs (memory and twiddle ROM share this latency).
- BF_LAT, 1, butterfly input-to-output register latency.
- Derived: D = RD_LAT + BF_LAT (must be >= 1); SW = max(1, $clog2(LOG2N)).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin an FFT; sampled only in IDLE
- busy  out  1  high from cycle after accepted start through DONE cycle inclusive
- done  out  1  one-cycle pulse, final write-back complete
- stage  out  SW  current stage index s, 0..LOG2N-1
- rd_en  out  1  butterfly read issue strobe
- rd_addr_a  out  LOG2N  operand A address
- rd_addr_b  out  LOG2N  operand B address
- tw_addr  out  LOG2N-1  twiddle ROM index, W_N^tw_addr
- wr_en  out  1  write-back strobe, aligned with butterfly outputs
- wr_addr_a  out  LOG2N  write address for butterfly O_A
- wr_addr_b  out  LOG2N  write address for butterfly O_B

Behaviour:
- Reset (async, immediate): state=IDLE, stage=0, k=0.
  - busy=0, done=0, rd_en=0, wr_en=0.
  - All addresses = 0 and the D-deep write delay line cleared.
  - Reset mid-run abandons the transform; no further wr_en until a new start.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN with s=0, k=0. start is ignored in every other state, and no queuing.
- RUN: rd_en=1 every cycle with butterfly counter k = 0..N/2-1. Per k:
  - h = 2**s, j = k mod h.
  - rd_addr_a = ((k>>s)<<(s+1)) | j.
  - rd_addr_b = rd_addr_a + h.
  - tw_addr = j << (LOG2N-1-s).
  - k=N/2-1 -> DRAIN with drain counter = D.
- DRAIN: rd_en=0 for exactly D cycles.
  - Exit: s<LOG2N-1 -> s+1, k=0, RUN; else -> DONE.
- DONE: done=1 and busy=1 for one cycle -> IDLE; busy drops the following cycle.
- Write path: wr_en, wr_addr_a, wr_addr_b are rd_en, rd_addr_a, rd_addr_b delayed by exactly D registered cycles.
  - Last write of a stage occurs in the final DRAIN cycle, so the next stage's first read never precedes it.
- Outputs rd_* and stage are registered. rd_addr/tw_addr hold their last values while rd_en=0 (don't-care but stable).
- Timing: start sampled at edge 0.
  - Stage s reads occupy cycles s*(N/2+D)+1 .. s*(N/2+D)+N/2.
  - done is high in cycle LOG2N*(N/2+D)+1.
  - Back-to-back start accepted the cycle after done.
- Within a stage the addresses are distinct, so no read/write collision occurs.

Test Plan:
- LOG2N=4, D=2, start pulse -> stage 0 reads: k=0 gives (0,1,tw 0), k=7 gives (14,15,tw 0); rd_en high cycles 1..8; rd_en low cycles 9..10; stage 1 reads begin cycle 11.
- Same run, check later stages -> stage 2, k=5 (cycle 26) gives a=9, b=13, tw=2; stage 3, k=3 (cycle 34) gives a=3, b=11, tw=3.
- Same run, check write path and completion -> wr_en/wr_addr equal rd_en/rd_addr delayed exactly 2 cycles; last wr_en in cycle 40; done=1 only in cycle 41; busy high cycles 1..41; busy low cycle 42.
- start held high through the whole run -> no restart mid-transform; second transform begins cycle 42, rd_en high cycle 43.
- rst asserted asynchronously at cycle 20 -> busy, rd_en, wr_en low immediately; no wr_en afterwards; next start restarts at stage 0, k=0.
- LOG2N=2, RD_LAT=0, BF_LAT=1 -> reads (0,1,0), (2,3,0) then (0,2,0), (1,3,1); done in cycle 2*(2+1)+1 = 7.
